// File: rtl/or1k_pkg.sv
// Shared definitions for the conditional-branch resolve tracker: state encoding,
// delay-slot offset and the l.bf/l.bnf taken rule.
package or1k_pkg;

   typedef logic [1:0] brt_state_t;

   localparam brt_state_t StEmpty    = 2'b00;
   localparam brt_state_t StPending  = 2'b01;
   localparam brt_state_t StResolved = 2'b10;

   // Fall-through skips the branch and its delay slot.
   localparam int unsigned DelaySlotOffset = 8;

   function automatic logic resolve_taken(input logic op_bf, input logic flag);
      return op_bf ? flag : ~flag;
   endfunction

endpackage

// File: rtl/or1k_sat_counter32.sv
// 32-bit event counter that sticks at all-ones; synchronous active-high reset.
module or1k_sat_counter32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/or1k_branch_resolve_tracker.sv
// Tracks one conditional branch from decode into execute, resolves it against SR[F] and
// pulses a mispredict with the corrected fetch PC. OR1K_BRANCH_PERF_COUNTERS_EN adds counters.
module or1k_branch_resolve_tracker
   import or1k_pkg::*;
#(
   parameter int unsigned OPTION_OPERAND_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            padv_decode_i,
   input  logic                            padv_execute_i,
   input  logic                            pipeline_flush_i,
   input  logic                            decode_op_bf_i,
   input  logic                            decode_op_bnf_i,
   input  logic                            predicted_flag_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] pc_decode_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] decode_branch_target_i,
   input  logic                            flag_i,
   input  logic                            flag_valid_i,
   output logic                            prev_op_brcond_o,
   output logic                            branch_mispredict_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o
`ifdef OR1K_BRANCH_PERF_COUNTERS_EN
   ,
   output logic [31:0]                     branch_count_o,
   output logic [31:0]                     mispredict_count_o
`endif
);

   localparam int unsigned W = OPTION_OPERAND_WIDTH;
   localparam logic [W-1:0] SlotOffset = W'(DelaySlotOffset);

   brt_state_t     state_q, state_d;
   logic           op_bf_q;
   logic           pred_q;
   logic [W-1:0]   target_q;
   logic [W-1:0]   fallthrough_q;
   logic           prev_op_brcond_q;

   logic           capture;
   logic           load;
   logic           resolve;
   logic           taken_now;
   logic           mispredict;

   assign capture = padv_decode_i & (decode_op_bf_i | decode_op_bnf_i);

   // An early padv_execute is treated as if the flag were already final.
   assign resolve   = (state_q == StPending) & (flag_valid_i | padv_execute_i) &
                      ~pipeline_flush_i & ~rst;
   assign taken_now = resolve_taken(op_bf_q, flag_i);
   assign mispredict = resolve & (taken_now != pred_q);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      if (pipeline_flush_i) begin
         state_d = StEmpty;
      end else begin
         case (state_q)
            StEmpty: begin
               if (capture) begin
                  state_d = StPending;
                  load    = 1'b1;
               end
            end
            StPending: begin
               if (resolve) begin
                  state_d = StResolved;
               end
            end
            StResolved: begin
               // A branch entering execute as the resolved one retires takes its place.
               if (padv_execute_i) begin
                  if (capture) begin
                     state_d = StPending;
                     load    = 1'b1;
                  end else begin
                     state_d = StEmpty;
                  end
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= StEmpty;
         op_bf_q          <= 1'b0;
         pred_q           <= 1'b0;
         target_q         <= '0;
         fallthrough_q    <= '0;
         prev_op_brcond_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         prev_op_brcond_q <= (state_d == StResolved);
         if (load) begin
            op_bf_q       <= decode_op_bf_i;
            pred_q        <= predicted_flag_i;
            target_q      <= decode_branch_target_i;
            fallthrough_q <= pc_decode_i + SlotOffset;
         end
      end
   end

   assign prev_op_brcond_o    = prev_op_brcond_q;
   assign branch_mispredict_o = mispredict;
   assign redirect_pc_o       = mispredict ? (taken_now ? target_q : fallthrough_q) : '0;

`ifdef OR1K_BRANCH_PERF_COUNTERS_EN
   or1k_sat_counter32 u_branch_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (resolve),
      .count_o (branch_count_o)
   );

   or1k_sat_counter32 u_mispredict_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (mispredict),
      .count_o (mispredict_count_o)
   );
`endif

endmodule
